// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the shift register family (shift_reg, shift_reg_piso).
//   - Shift FSM state encoding (ST_IDLE / ST_SHIFT / ST_PAR) and its enum type.
//   - Bit-order selector values (DIR_MSB_FIRST / DIR_LSB_FIRST).
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_PAR   = ST_PAR
  } state_t;

endpackage : shift_pkg

// File: rtl/shift_reg_piso.sv
// -----------------------------------------------------------------------------
// shift_reg_piso
//   Parallel-in / serial-out shift register. A word is taken over a
//   valid/ready handshake and then sent one bit per enabled clock, MSB-first
//   (dir=0) or LSB-first (dir=1). The bit order is latched at acceptance.
//
//   Optional feature (macro SHIFT_PISO_PARITY_EN): an even-parity bit of the
//   accepted word is sent in an extra PAR state after the last data bit.
//   Default build (macro undefined): data bits only.
//
// Parameters
//   MSB         word width in bits (>= 2)
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   en          shift enable; 0 stalls and holds the current bit
//   dir         0 = MSB-first, 1 = LSB-first (sampled at acceptance only)
//   load_valid  din carries a word to send
//   load_ready  block can accept a word (IDLE only)
//   din         parallel word
//   q           serial data bit
//   q_valid     q carries a valid bit this cycle
//   busy        word in flight (SHIFT or PAR)
//   done        one-cycle pulse after the final bit was consumed
// -----------------------------------------------------------------------------
module shift_reg_piso
  import shift_pkg::*;
#(
  parameter int MSB = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           dir,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [MSB-1:0] din,
  output logic           q,
  output logic           q_valid,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(MSB);

  state_t         state;
  state_t         state_nx;
  logic [MSB-1:0] sr;
  logic [CW-1:0]  cnt;
  logic           dir_q;
  logic           accept;
  logic           last_data;
  logic           finish;
  logic           par_bit;

`ifdef SHIFT_PISO_PARITY_EN
  logic par_q;
  assign par_bit = par_q;
`else
  assign par_bit = 1'b0;
`endif

  assign accept    = load_valid && load_ready;
  // The bit currently on q is the last data bit when cnt has reached zero.
  assign last_data = (state == S_SHIFT) && en && (cnt == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nx = state;
    finish   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_data) begin
`ifdef SHIFT_PISO_PARITY_EN
          state_nx = S_PAR;
`else
          state_nx = S_IDLE;
          finish   = 1'b1;
`endif
        end
      end
      S_PAR: begin
        if (en) begin
          state_nx = S_IDLE;
          finish   = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state <= S_IDLE;
      sr    <= '0;
      cnt   <= '0;
      dir_q <= DIR_MSB_FIRST;
      done  <= 1'b0;
`ifdef SHIFT_PISO_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      done  <= finish;
      if (accept) begin
        sr    <= din;
        dir_q <= dir;
        cnt   <= CW'(MSB - 1);
`ifdef SHIFT_PISO_PARITY_EN
        par_q <= ^din;
`endif
      end else if ((state == S_SHIFT) && en) begin
        // Zero fill means sr is empty again once the word has left.
        if (dir_q == DIR_LSB_FIRST) sr <= {1'b0, sr[MSB-1:1]};
        else                        sr <= {sr[MSB-2:0], 1'b0};
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign load_ready = (state == S_IDLE);
  assign busy       = (state == S_SHIFT) || (state == S_PAR);
  assign q_valid    = busy;

  always_comb begin
    q = 1'b0;
    if (state == S_SHIFT)    q = (dir_q == DIR_MSB_FIRST) ? sr[MSB-1] : sr[0];
    else if (state == S_PAR) q = par_bit;
  end

endmodule : shift_reg_piso

// File: tb/tb_shift_reg_piso.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_piso
//   Self-checking bench for shift_reg_piso (MSB=16). A reference model keeps
//   the bits still to be sent in a queue; outputs follow from the queue alone.
//   Honours SHIFT_PISO_PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_shift_reg_piso;

  localparam int W = 16;
`ifdef SHIFT_PISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_ready;
  logic         q;
  logic         q_valid;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  bit mq[$];
  bit m_done;

  shift_reg_piso #(.MSB(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dir        (dir),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .din        (din),
    .q          (q),
    .q_valid    (q_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the word becomes an ordered list of bits at acceptance;
  // each enabled cycle removes the front bit.
  task automatic model_step(input logic r, input logic e, input logic d,
                            input logic lv, input logic [W-1:0] w);
    if (r) begin
      mq.delete();
      m_done = 1'b0;
    end else if (mq.size() == 0) begin
      m_done = 1'b0;
      if (lv) begin
        for (int i = 0; i < W; i++) mq.push_back(d ? w[i] : w[W-1-i]);
`ifdef SHIFT_PISO_PARITY_EN
        mq.push_back(^w);
`endif
      end
    end else if (e) begin
      void'(mq.pop_front());
      m_done = (mq.size() == 0);
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic check_model();
    bit has = (mq.size() != 0);
    check("q",          32'(q),          32'(has ? mq[0] : 1'b0));
    check("q_valid",    32'(q_valid),    32'(has));
    check("busy",       32'(busy),       32'(has));
    check("load_ready", 32'(load_ready), 32'(!has));
    check("done",       32'(done),       32'(m_done));
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic cycle(input logic r, input logic e, input logic d,
                       input logic lv, input logic [W-1:0] w);
    rst = r; en = e; dir = d; load_valid = lv; din = w;
    @(posedge clk);
    model_step(r, e, d, lv, w);
    #1;
    check_model();
  endtask

  // Sends one word from IDLE with en=1 except for an optional stall; optionally
  // toggles dir every cycle, or aborts with reset once abort_at bits are out.
  task automatic send_word(input logic [W-1:0] w, input logic d, input bit toggle,
                           input int stall_at, input int stall_len, input int abort_at,
                           output logic [NB-1:0] rx, output int nbits,
                           output int ncyc, output bit saw_done);
    int   stalled = 0;
    logic dd = d;
    logic e;
    rx = '0; nbits = 0; ncyc = 0; saw_done = 1'b0;
    cycle(1'b0, 1'b1, d, 1'b1, w);
    while (!saw_done && ncyc < 40) begin
      if (nbits == abort_at) begin
        cycle(1'b1, 1'b1, dd, 1'b0, '0);
        return;
      end
      e = !(nbits == stall_at && stalled < stall_len);
      if (!e) stalled++;
      if (e && q_valid) begin
        rx = {rx[NB-2:0], q};
        nbits++;
      end
      if (toggle) dd = ~dd;
      cycle(1'b0, e, dd, 1'b0, ~w);
      ncyc++;
      if (done) saw_done = 1'b1;
    end
  endtask

  typedef struct {
    logic         rst;
    logic         en;
    logic         dir;
    logic         lv;
    logic [W-1:0] din;
    logic         q;
    logic         qv;
    logic         busy;
    logic         done;
    logic         lr;
  } vec_t;

  initial begin
    vec_t            vt[8];
    logic [NB-1:0]   rx;
    logic [NB-1:0]   exp_rx;
    int              nbits;
    int              ncyc;
    bit              sd;
    int              accepts;
    logic [W-1:0]    wr;

    // Reset, accept A5C3 MSB-first, a few bits with a stall, then reset mid-word.
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hA5C3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cycle(vt[i].rst, vt[i].en, vt[i].dir, vt[i].lv, vt[i].din);
      check($sformatf("vec%0d_q", i),    32'(q),          32'(vt[i].q));
      check($sformatf("vec%0d_qv", i),   32'(q_valid),    32'(vt[i].qv));
      check($sformatf("vec%0d_busy", i), 32'(busy),       32'(vt[i].busy));
      check($sformatf("vec%0d_done", i), 32'(done),       32'(vt[i].done));
      check($sformatf("vec%0d_lr", i),   32'(load_ready), 32'(vt[i].lr));
    end

    // Full word MSB-first.
    send_word(16'hA5C3, 1'b0, 1'b0, -1, 0, -1, rx, nbits, ncyc, sd);
`ifdef SHIFT_PISO_PARITY_EN
    exp_rx = {16'hA5C3, 1'b0};
`else
    exp_rx = 16'hA5C3;
`endif
    check("a5c3_bits", 32'(rx), 32'(exp_rx));
    check("a5c3_done", 32'(sd), 32'd1);
    check("a5c3_cycles", 32'(ncyc), 32'(NB));
    check("a5c3_ready", 32'(load_ready), 32'd1);

    // LSB-first, dir toggled every cycle mid-word.
    send_word(16'h0001, 1'b1, 1'b1, -1, 0, -1, rx, nbits, ncyc, sd);
`ifdef SHIFT_PISO_PARITY_EN
    exp_rx = {16'h8000, 1'b1};
`else
    exp_rx = 16'h8000;
`endif
    check("lsb_bits", 32'(rx), 32'(exp_rx));
    check("lsb_done", 32'(sd), 32'd1);

    // Stall three cycles after four bits.
    send_word(16'hFF00, 1'b0, 1'b0, 4, 3, -1, rx, nbits, ncyc, sd);
`ifdef SHIFT_PISO_PARITY_EN
    exp_rx = {16'hFF00, 1'b0};
`else
    exp_rx = 16'hFF00;
`endif
    check("stall_bits", 32'(rx), 32'(exp_rx));
    check("stall_nbits", 32'(nbits), 32'(NB));
    check("stall_cycles", 32'(ncyc), 32'(NB + 3));

    // load_valid held through a whole word: exactly one more accept after done.
    accepts = 0;
    for (int i = 0; i < NB + 3; i++) begin
      if (load_ready) accepts++;
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    end
    check("hold_accepts", 32'(accepts), 32'd2);
    check("hold_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NB + 2 && busy; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("hold_drained", 32'(busy), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Reset at bit 7: back to IDLE, no done.
    send_word(16'hFFFF, 1'b0, 1'b0, -1, 0, 7, rx, nbits, ncyc, sd);
    check("abort_nbits", 32'(nbits), 32'd7);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(load_ready), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("abort_done_after", 32'(done), 32'd0);

    // Odd population count word.
    send_word(16'h0007, 1'b0, 1'b0, -1, 0, -1, rx, nbits, ncyc, sd);
`ifdef SHIFT_PISO_PARITY_EN
    exp_rx = {16'h0007, 1'b1};
`else
    exp_rx = 16'h0007;
`endif
    check("w0007_bits", 32'(rx), 32'(exp_rx));
    check("w0007_cycles", 32'(ncyc), 32'(NB));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      wr = W'($urandom);
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 9) < 3), wr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_reg_piso
